// File: rtl/fsm_segment_capture.sv
// Rebuilds the six stopwatch digits from the multiplexed display bus and tracks frame lock.
// Optional BCD_CHECK_EN: when defined, digit values above 9 are rejected and flagged on err_bcd.
module fsm_segment_capture #(
  parameter int LOCK_TIMEOUT = 1024,
  parameter int TO_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic [3:0] bcd_in,
  input  logic [5:0] sel_in,
  output logic [3:0] d_ms0,
  output logic [3:0] d_ms1,
  output logic [3:0] d_s0,
  output logic [3:0] d_s1,
  output logic [3:0] d_m0,
  output logic [3:0] d_m1,
  output logic       frame_valid,
  output logic       locked,
  output logic       err_sel,
  output logic       err_bcd
);

  // state | meaning
  // HUNT  | waiting for digit 0 to start a frame, not locked
  // TRACK | following the scan order, locked
  typedef enum logic {HUNT, TRACK} state_t;

  localparam logic [5:0]      SEL_FIRST = 6'b10_0000;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [4:0][3:0] shadow_q;
  logic [5:0][3:0] dout_q;
  logic            frame_valid_q, locked_q, err_sel_q, err_bcd_q;

  logic [5:0] sel_exp;
  logic       bcd_ok, sel_first, in_track;
  logic       accept, sel_err, bcd_err, resync, hunt_start, frame_done;
  logic       shadow_we;
  logic [2:0] shadow_idx;

  always_comb begin
    sel_exp   = SEL_FIRST >> idx_q;
    sel_first = (sel_in == SEL_FIRST);
    in_track  = (state_q == TRACK);
`ifdef BCD_CHECK_EN
    bcd_ok    = (bcd_in <= 4'd9);
    bcd_err   = sample_en && in_track && !bcd_ok;
`else
    bcd_ok    = 1'b1;
    bcd_err   = 1'b0;
`endif
    sel_err    = sample_en && in_track && (sel_in != sel_exp);
    accept     = sample_en && in_track && (sel_in == sel_exp) && bcd_ok;
    // Digit 0 out of turn restarts the frame rather than dropping lock.
    resync     = sel_err && !bcd_err && sel_first;
    hunt_start = sample_en && !in_track && sel_first && bcd_ok;
    frame_done = accept && (idx_q == 3'd5);
    shadow_we  = hunt_start || resync || (accept && (idx_q != 3'd5));
    shadow_idx = (hunt_start || resync) ? 3'd0 : idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      idx_q    <= 3'd0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      HUNT: begin
        to_cnt_d = '0;
        if (hunt_start) begin
          state_d = TRACK;
          idx_d   = 3'd1;
        end
      end
      TRACK: begin
        if ((sel_err && !resync) || bcd_err) begin
          state_d  = HUNT;
          idx_d    = 3'd0;
          to_cnt_d = '0;
        end else if (resync) begin
          idx_d    = 3'd1;
          to_cnt_d = '0;
        end else if (accept) begin
          idx_d    = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
          to_cnt_d = '0;
        end else if (to_cnt_q >= TO_LAST) begin
          state_d  = HUNT;
          idx_d    = 3'd0;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q      <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      err_sel_q     <= 1'b0;
      err_bcd_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (shadow_we && (shadow_idx == 3'(i))) shadow_q[i] <= bcd_in;
      end
      if (frame_done) dout_q <= {bcd_in, shadow_q};
      frame_valid_q <= frame_done;
      locked_q      <= (state_d == TRACK);
      err_sel_q     <= sel_err;
      err_bcd_q     <= bcd_err;
    end
  end

  always_comb begin
    d_ms0       = dout_q[0];
    d_ms1       = dout_q[1];
    d_s0        = dout_q[2];
    d_s1        = dout_q[3];
    d_m0        = dout_q[4];
    d_m1        = dout_q[5];
    frame_valid = frame_valid_q;
    locked      = locked_q;
    err_sel     = err_sel_q;
    err_bcd     = err_bcd_q;
  end

endmodule

// File: tb/tb_fsm_segment_capture.sv
// Directed bench for fsm_segment_capture; expectations are hand-computed per scenario.
module tb_fsm_segment_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_en = 1'b0;
  logic [3:0] bcd_in = 4'd0;
  logic [5:0] sel_in = 6'd0;
  logic [3:0] d_ms0, d_ms1, d_s0, d_s1, d_m0, d_m1;
  logic       frame_valid, locked, err_sel, err_bcd;

  int n_chk = 0;
  int n_err = 0;

  fsm_segment_capture #(.LOCK_TIMEOUT(8), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .bcd_in(bcd_in), .sel_in(sel_in),
    .d_ms0(d_ms0), .d_ms1(d_ms1), .d_s0(d_s0), .d_s1(d_s1), .d_m0(d_m0), .d_m1(d_m1),
    .frame_valid(frame_valid), .locked(locked), .err_sel(err_sel), .err_bcd(err_bcd)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive on negedge, return 1 time unit after the sampling edge.
  task automatic drive(input logic en, input logic [5:0] sel, input logic [3:0] bcd);
    @(negedge clk);
    sample_en = en;
    sel_in    = sel;
    bcd_in    = bcd;
    @(posedge clk);
    #1;
  endtask

  task automatic send_digits(input int first, input int last, input logic [5:0][3:0] v);
    logic [5:0] s;
    for (int i = first; i <= last; i++) begin
      s = 6'b10_0000 >> i;
      drive(1'b1, s, v[i]);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [5:0][3:0] v);
    chk({tag, ".ms0"}, 32'(d_ms0), 32'(v[0]));
    chk({tag, ".ms1"}, 32'(d_ms1), 32'(v[1]));
    chk({tag, ".s0"},  32'(d_s0),  32'(v[2]));
    chk({tag, ".s1"},  32'(d_s1),  32'(v[3]));
    chk({tag, ".m0"},  32'(d_m0),  32'(v[4]));
    chk({tag, ".m1"},  32'(d_m1),  32'(v[5]));
  endtask

  logic [5:0][3:0] f1, f2, f3, f4, f5, f6;
  logic            err_seen;

  initial begin
    // element 0 is ms0
    f1 = {4'd1, 4'd2, 4'd9, 4'd5, 4'd4, 4'd3};
    f2 = {4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    f3 = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd7};
    f4 = {4'd6, 4'd6, 4'd6, 4'hC, 4'd2, 4'd1};
    f5 = {4'd0, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5};

    #25;
    chk("rst.locked", 32'(locked), 0);
    chk("rst.fv", 32'(frame_valid), 0);
    chk("rst.err", 32'({err_sel, err_bcd}), 0);
    chk_frame("rst", '0);
    @(negedge clk);
    rst_n = 1'b1;

    // HUNT ignores other selects silently
    drive(1'b1, 6'b00_0100, 4'd5);
    chk("hunt.err_sel", 32'(err_sel), 0);
    chk("hunt.locked", 32'(locked), 0);

    // 1: two full frames, pulse spacing 6 cycles
    send_digits(0, 4, f1);
    chk("t1.fv_early", 32'(frame_valid), 0);
    chk("t1.locked_mid", 32'(locked), 1);
    send_digits(5, 5, f1);
    chk("t1.fv", 32'(frame_valid), 1);
    chk("t1.locked", 32'(locked), 1);
    chk_frame("t1", f1);
    send_digits(0, 0, f1);
    chk("t1.fv_width", 32'(frame_valid), 0);
    send_digits(1, 4, f1);
    chk("t1.fv_gap", 32'(frame_valid), 0);
    send_digits(5, 5, f1);
    chk("t1.fv2", 32'(frame_valid), 1);

    // 2: skipped select at idx 3
    send_digits(0, 2, f2);
    drive(1'b1, 6'b00_0010, 4'd5);
    chk("t2.err_sel", 32'(err_sel), 1);
    chk("t2.locked", 32'(locked), 0);
    chk("t2.fv", 32'(frame_valid), 0);
    chk_frame("t2.hold", f1);
    send_digits(0, 0, f2);
    chk("t2.err_width", 32'(err_sel), 0);
    chk("t2.relock", 32'(locked), 1);
    send_digits(1, 5, f2);
    chk("t2.fv", 32'(frame_valid), 1);
    chk_frame("t2", f2);

    // 3: digit 0 arriving mid-frame resyncs
    drive(1'b1, 6'b10_0000, 4'd1);
    drive(1'b1, 6'b01_0000, 4'd1);
    drive(1'b1, 6'b10_0000, 4'd7);
    chk("t3.err_sel", 32'(err_sel), 1);
    chk("t3.locked", 32'(locked), 1);
    send_digits(1, 5, f3);
    chk("t3.fv", 32'(frame_valid), 1);
    chk_frame("t3", f3);

    // 4: digit value 0xC at digit 2
    send_digits(0, 2, f4);
`ifdef BCD_CHECK_EN
    chk("t4.err_bcd", 32'(err_bcd), 1);
    chk("t4.err_sel", 32'(err_sel), 0);
    chk("t4.locked", 32'(locked), 0);
    chk_frame("t4.hold", f3);
    drive(1'b1, 6'b10_0000, 4'hB);
    chk("t4.hunt_bad_bcd", 32'(locked), 0);
    chk("t4.hunt_no_err", 32'({err_sel, err_bcd}), 0);
`else
    chk("t4.err_bcd", 32'(err_bcd), 0);
    chk("t4.locked", 32'(locked), 1);
    send_digits(3, 5, f4);
    chk("t4.fv", 32'(frame_valid), 1);
    chk_frame("t4", f4);
`endif
    f6 = {d_m1, d_m0, d_s1, d_s0, d_ms1, d_ms0};

    // 5: timeout of 8 idle cycles while locked
    send_digits(0, 5, f5);
    chk("t5.fv", 32'(frame_valid), 1);
    chk_frame("t5", f5);
    err_seen = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 6'b00_0000, 4'd0);
      err_seen = err_seen | err_sel | err_bcd | frame_valid;
      chk($sformatf("t5.locked%0d", k), 32'(locked), (k < 8) ? 1 : 0);
    end
    chk("t5.no_pulse", 32'(err_seen), 0);
    chk_frame("t5.hold", f5);
    // stays in HUNT: a non-first select is not an error
    drive(1'b1, 6'b01_0000, 4'd1);
    chk("t5.hunt", 32'({locked, err_sel}), 0);

    // 6: asynchronous reset mid-frame
    send_digits(0, 2, f2);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    chk("t6.locked", 32'(locked), 0);
    chk_frame("t6.rst", '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_digits(0, 5, f5);
    chk("t6.fv", 32'(frame_valid), 1);
    chk("t6.locked_after", 32'(locked), 1);
    chk_frame("t6", f5);
    if (f6 == '0) chk("t6.sanity", 32'(f6), 32'(f6) + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
